aes_sched: RTL
==============

AES_SCHED -- requirements
Module: aes_sched

Interface
REQ-001 The block SHALL have parameter CAP_DLY, default 12: cycles from the core Start cycle to the cycle presenting the high output half.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 2 bits: per-requester request valid, where bit i is requester i.
REQ-005 The block SHALL have port req_ready, output, 2 bits: per-requester accept strobe.
REQ-006 The block SHALL have port req_mode, input, 2 bits: per-requester mode, where 0 is encrypt and 1 is decrypt.
REQ-007 The block SHALL have ports req_data and req_key, input, 256 bits each: requester i uses bits [128i+127:128i].
REQ-008 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1) and rsp_id (output, 1): response handshake and the index of the served requester.
REQ-009 The block SHALL have ports rsp_text and rsp_key, output, 128 bits each: the core's 128-bit result and its 128-bit final round key.
REQ-010 The block SHALL have ports core_start and core_select, output, 1 bit each: the core's Start and Select inputs.
REQ-011 The block SHALL have ports core_data and core_key, output, 64 bits each: the core's DATA and KEY half-beat inputs.
REQ-012 The block SHALL have ports core_text and core_key10, input, 64 bits each: the core's Cipher_text and KEY10 half-beat outputs.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL use the states IDLE, LOAD_HI, LOAD_LO, WAIT, CAP_HI, CAP_LO and RESP.
REQ-015 In IDLE, req_ready SHALL be one-hot for the granted requester with valid high, combinationally, and zero if no requester is valid.
- On valid&ready, the block latches data, key, mode and id, then moves to LOAD_HI.
REQ-016 In LOAD_HI (cycle 0), the block SHALL drive core_start=1, core_select=mode, core_data=data[127:64] and core_key=key[127:64].
REQ-017 In LOAD_LO (cycle 1), the block SHALL drive core_start=0, core_data=data[63:0] and core_key=key[63:0].
- core_select stays at mode for cycles 0 through CAP_DLY+1.
REQ-018 Outside LOAD_HI and LOAD_LO, core_data and core_key SHALL be zero and core_start SHALL be 0.
REQ-019 WAIT SHALL count with a down-counter sized by $clog2(CAP_DLY+1), with no wrap.
- CAP_HI occurs at cycle CAP_DLY and registers core_text/core_key10 into rsp_text[127:64] and rsp_key[127:64].
REQ-020 CAP_LO SHALL occur at cycle CAP_DLY+1 and register the inputs into rsp_text[63:0] and rsp_key[63:0].
REQ-021 RESP SHALL start at cycle CAP_DLY+2 and assert rsp_valid.
- rsp_valid, rsp_text, rsp_key and rsp_id stay stable until rsp_valid&rsp_ready.
- The FSM then goes to IDLE and rsp_valid drops next cycle.
REQ-022 The block SHALL accept no new request outside IDLE, and req_ready SHALL be 0 there.
- A requester SHALL hold req_valid until it is accepted.
- Dropping req_valid before acceptance SHALL be legal and SHALL have no effect.
REQ-023 Back-to-back operation SHALL work as follows: a response handshake in cycle k puts the FSM in IDLE in cycle k+1, where a new grant is possible.

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, and SHALL hold at 0 every output, the grant pointer and all captured registers.
REQ-025 Reset mid-operation SHALL abandon the transaction with no response, and the core SHALL see core_start=0.
REQ-026 After reset deasserts, the first rising edge SHALL be able to grant.

Configuration
REQ-027 With AES_SCHED_RR_EN defined, arbitration SHALL be round-robin: the pointer starts at 0 and after each grant moves to the other requester.
REQ-028 Without AES_SCHED_RR_EN, requester 0 SHALL have fixed priority over requester 1, and no pointer SHALL exist.

Verification
REQ-029 Encrypt test: req0, mode 0, key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734.
- Required: a single-cycle core_start carrying 3243f6a8885a308d, then 313198a2e0370734.
- Required: rsp_valid at cycle 14, rsp_text=3925841d02dc09fbdc118597196a0b32, rsp_id=0.
REQ-030 Decrypt test: req1, mode 1, with the ciphertext and KEY10 from REQ-029.
- Required: core_select=1 during cycles 0-13, rsp_text=3243f6a8885a308d313198a2e0370734, rsp_id=1.
REQ-031 Arbitration test: both req_valid held high for 4 transactions.
- With AES_SCHED_RR_EN: rsp_id sequence 0,1,0,1.
- Without it: 0,0,0,0.
REQ-032 Backpressure test: rsp_ready low for 5 cycles in RESP.
- Required: rsp_valid and rsp_text stable, req_ready=0, busy=1.
- Required: IDLE one cycle after rsp_ready rises.
REQ-033 Reset test: reset pulsed during WAIT at cycle 6.
- Required: all outputs 0 with no clock edge and no response.
- Required: the next request completes as in REQ-029.
REQ-034 Idle test: no req_valid for 20 cycles.
- Required: req_ready=0, busy=0, core_start=0 throughout.

Source files
------------

// File: rtl/aes_sched.sv
// aes_sched: two-requester scheduler feeding a 64-bit half-beat AES core and collecting its result.
// Define AES_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module aes_sched #(
    parameter int CAP_DLY = 12  // must be >= 3 so at least one WAIT cycle exists
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req_mode,
    input  logic [255:0] req_data,
    input  logic [255:0] req_key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_text,
    output logic [127:0] rsp_key,
    output logic         core_start,
    output logic         core_select,
    output logic [63:0]  core_data,
    output logic [63:0]  core_key,
    input  logic [63:0]  core_text,
    input  logic [63:0]  core_key10,
    output logic         busy
);
    localparam int            CW       = $clog2(CAP_DLY + 1);
    localparam logic [CW-1:0] WAIT_LEN = CW'(CAP_DLY - 3);

    typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, WAIT, CAP_HI, CAP_LO, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [63:0]   data_lo;
    logic [63:0]   key_lo;
    logic          gnt_id;

`ifdef AES_SCHED_RR_EN
    logic ptr;

    assign gnt_id = req_valid[ptr] ? ptr : ~ptr;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset)           ptr <= 1'b0;
        else if (|req_ready) ptr <= ~gnt_id;
    end
`else
    assign gnt_id = req_valid[0] ? 1'b0 : 1'b1;
`endif

    // Grant is combinational so a request can be taken on the first edge in IDLE.
    assign req_ready = (state == IDLE && !reset && |req_valid) ? (2'b01 << gnt_id) : 2'b00;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            data_lo     <= '0;
            key_lo      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_text    <= '0;
            rsp_key     <= '0;
            core_start  <= 1'b0;
            core_select <= 1'b0;
            core_data   <= '0;
            core_key    <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_ready) begin
                    state       <= LOAD_HI;
                    busy        <= 1'b1;
                    rsp_id      <= gnt_id;
                    core_start  <= 1'b1;
                    core_select <= req_mode[gnt_id];
                    core_data   <= req_data[{gnt_id, 7'd64} +: 64];
                    core_key    <= req_key[{gnt_id, 7'd64} +: 64];
                    data_lo     <= req_data[{gnt_id, 7'd0} +: 64];
                    key_lo      <= req_key[{gnt_id, 7'd0} +: 64];
                end
                LOAD_HI: begin
                    state      <= LOAD_LO;
                    core_start <= 1'b0;
                    core_data  <= data_lo;
                    core_key   <= key_lo;
                    cnt        <= WAIT_LEN;
                end
                LOAD_LO: begin
                    state     <= WAIT;
                    core_data <= '0;
                    core_key  <= '0;
                end
                WAIT: begin
                    if (cnt == '0) state <= CAP_HI;
                    else           cnt   <= cnt - CW'(1);
                end
                CAP_HI: begin
                    state            <= CAP_LO;
                    rsp_text[127:64] <= core_text;
                    rsp_key[127:64]  <= core_key10;
                end
                CAP_LO: begin
                    state          <= RESP;
                    rsp_text[63:0] <= core_text;
                    rsp_key[63:0]  <= core_key10;
                    core_select    <= 1'b0;
                    rsp_valid      <= 1'b1;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
